// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit (IDLE/LOAD/STORE/RESP).
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete with an error and no memory activity.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_is_store,
    input  logic [1:0]                        req_size,
    input  logic                              req_signed,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]             req_wdata,
    output logic                              resp_valid,
    output logic [DATA_WIDTH-1:0]             resp_data,
    output logic                              resp_error,
    output logic [ADDR_WIDTH-1:0]             fetch_addr,
    input  logic [DATA_WIDTH-1:0]             fetched_data,
    input  logic                              fetch_done,
    output logic [ADDR_WIDTH-1:0]             write_addr,
    output logic [DATA_WIDTH-1:0]             write_data,
    output logic [$clog2(DATA_WIDTH/8):0]     bytes_to_write,
    output logic                              write_data_valid,
    input  logic                              write_done
);
    localparam int IW = $clog2(DATA_WIDTH/8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_wdv;
    logic [IW:0]           r_bytes;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_error;

    logic                  w_misaligned;
    logic                  w_reject;
    logic [IW:0]           w_bytes;
    logic [DATA_WIDTH-1:0] w_load_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                          ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_reject = (req_size == 2'd3) || w_misaligned;

    always_comb begin
        w_bytes = (IW+1)'(4);
        case (req_size)
            2'd0:    w_bytes = (IW+1)'(1);
            2'd1:    w_bytes = (IW+1)'(2);
            default: w_bytes = (IW+1)'(4);
        endcase
    end

    // Sized casts of signed slices sign-extend; unsigned slices zero-extend.
    always_comb begin
        w_load_ext = '0;
        case (r_size)
            2'd0: w_load_ext = r_signed ? DATA_WIDTH'($signed(fetched_data[7:0]))
                                        : DATA_WIDTH'(fetched_data[7:0]);
            2'd1: w_load_ext = r_signed ? DATA_WIDTH'($signed(fetched_data[15:0]))
                                        : DATA_WIDTH'(fetched_data[15:0]);
            default: w_load_ext = r_signed ? DATA_WIDTH'($signed(fetched_data[31:0]))
                                           : DATA_WIDTH'(fetched_data[31:0]);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wdv        <= 1'b0;
            r_bytes      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_size       <= req_size;
                        r_signed     <= req_signed;
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_resp_data  <= '0;
                        r_resp_error <= 1'b0;
                        if (w_reject) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else if (req_is_store) begin
                            r_state <= S_STORE;
                            r_wdv   <= 1'b1;
                            r_bytes <= w_bytes;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (fetch_done) begin
                        r_resp_data  <= w_load_ext;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_STORE: begin
                    if (write_done) begin
                        r_wdv        <= 1'b0;
                        r_bytes      <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready        = (r_state == S_IDLE);
    assign resp_valid       = r_resp_valid;
    assign resp_data        = r_resp_data;
    assign resp_error       = r_resp_error;
    assign fetch_addr       = r_addr;
    assign write_addr       = r_addr;
    assign write_data       = r_wdata;
    assign bytes_to_write   = r_bytes;
    assign write_data_valid = r_wdv;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_data, fetch_addr, fetched_data, write_addr, write_data;
    logic        fetch_done, write_data_valid, write_done;
    logic [2:0]  bytes_to_write;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
        .fetch_addr(fetch_addr), .fetched_data(fetched_data), .fetch_done(fetch_done),
        .write_addr(write_addr), .write_data(write_data), .bytes_to_write(bytes_to_write),
        .write_data_valid(write_data_valid), .write_done(write_done)
    );

    // Called 1 time unit after a posedge with the unit idle; returns 1 unit after the accept edge.
    task automatic drive_req(input logic st, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_is_store = st; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic next_cycle;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #2;
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready act=%0b exp=1", req_ready); end
        tests_run++; if (resp_valid !== 1'b0 || resp_error !== 1'b0) begin tests_failed++; $display("FAIL rst_resp act=%0b/%0b exp=0/0", resp_valid, resp_error); end
        tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata act=%h exp=0", resp_data); end
        tests_run++; if (write_data_valid !== 1'b0 || bytes_to_write !== 3'd0) begin tests_failed++; $display("FAIL rst_write act=%0b/%0d exp=0/0", write_data_valid, bytes_to_write); end
        tests_run++; if (fetch_addr !== 32'h0 || write_addr !== 32'h0 || write_data !== 32'h0) begin tests_failed++; $display("FAIL rst_addr act=%h/%h/%h exp=0", fetch_addr, write_addr, write_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_store_word;
        write_done = 1'b1;
        drive_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
        tests_run++; if (write_data_valid !== 1'b1) begin tests_failed++; $display("FAIL sw_wdv act=%0b exp=1", write_data_valid); end
        tests_run++; if (bytes_to_write !== 3'd4) begin tests_failed++; $display("FAIL sw_bytes act=%0d exp=4", bytes_to_write); end
        tests_run++; if (write_addr !== 32'h100 || write_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_addr_data act=%h/%h exp=100/deadbeef", write_addr, write_data); end
        tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin tests_failed++; $display("FAIL sw_early act=%0b/%0b exp=0/0", resp_valid, req_ready); end
        next_cycle();
        tests_run++; if (resp_valid !== 1'b1 || resp_error !== 1'b0) begin tests_failed++; $display("FAIL sw_resp act=%0b/%0b exp=1/0", resp_valid, resp_error); end
        tests_run++; if (write_data_valid !== 1'b0 || bytes_to_write !== 3'd0) begin tests_failed++; $display("FAIL sw_wdv_drop act=%0b/%0d exp=0/0", write_data_valid, bytes_to_write); end
        tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("FAIL sw_rdata act=%h exp=0", resp_data); end
        next_cycle();
        tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL sw_idle act=%0b/%0b exp=0/1", resp_valid, req_ready); end
        write_done = 1'b0;
    endtask

    task automatic test_store_stall;
        int wdv_cycles = 0;
        int pulses = 0;
        write_done = 1'b0;
        drive_req(1'b1, 2'd0, 1'b0, 32'h1234, 32'h0000_00A5);
        tests_run++; if (bytes_to_write !== 3'd1) begin tests_failed++; $display("FAIL ss_bytes act=%0d exp=1", bytes_to_write); end
        for (int c = 0; c < 4; c++) begin
            if (c == 3) write_done = 1'b1;
            if (write_data_valid === 1'b1) wdv_cycles++;
            tests_run++; if (write_addr !== 32'h1234 || write_data !== 32'h0000_00A5 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL ss_stable c=%0d act=%h/%h/%0b exp=1234/a5/0", c, write_addr, write_data, resp_valid); end
            next_cycle();
        end
        write_done = 1'b0;
        tests_run++; if (wdv_cycles !== 4) begin tests_failed++; $display("FAIL ss_wdv_cycles act=%0d exp=4", wdv_cycles); end
        for (int c = 0; c < 4; c++) begin
            if (resp_valid === 1'b1) pulses++;
            next_cycle();
        end
        tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL ss_pulses act=%0d exp=1", pulses); end
    endtask

    task automatic test_load;
        fetch_done = 1'b1;
        fetched_data = 32'h0000_0080;
        drive_req(1'b0, 2'd0, 1'b1, 32'h200, 32'h0);
        tests_run++; if (fetch_addr !== 32'h200 || write_data_valid !== 1'b0) begin tests_failed++; $display("FAIL lb_fetch act=%h/%0b exp=200/0", fetch_addr, write_data_valid); end
        next_cycle();
        tests_run++; if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FF80) begin tests_failed++; $display("FAIL lb_signed act=%0b/%h exp=1/ffffff80", resp_valid, resp_data); end
        next_cycle();
        drive_req(1'b0, 2'd0, 1'b0, 32'h200, 32'h0);
        next_cycle();
        tests_run++; if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0080) begin tests_failed++; $display("FAIL lbu act=%0b/%h exp=1/00000080", resp_valid, resp_data); end
        next_cycle();
        fetched_data = 32'hABCD_7FFF;
        drive_req(1'b0, 2'd1, 1'b1, 32'h204, 32'h0);
        next_cycle();
        tests_run++; if (resp_data !== 32'h0000_7FFF) begin tests_failed++; $display("FAIL lh_pos act=%h exp=00007fff", resp_data); end
        next_cycle();
        fetched_data = 32'h0000_8001;
        drive_req(1'b0, 2'd1, 1'b1, 32'h206, 32'h0);
        next_cycle();
        tests_run++; if (resp_data !== 32'hFFFF_8001) begin tests_failed++; $display("FAIL lh_neg act=%h exp=ffff8001", resp_data); end
        next_cycle();
        // Stalled word load: two cycles without fetch_done.
        fetch_done = 1'b0;
        fetched_data = 32'h1234_5678;
        drive_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
        next_cycle();
        tests_run++; if (resp_valid !== 1'b0 || fetch_addr !== 32'h300) begin tests_failed++; $display("FAIL lw_stall act=%0b/%h exp=0/300", resp_valid, fetch_addr); end
        fetch_done = 1'b1;
        next_cycle();
        fetch_done = 1'b0;
        tests_run++; if (resp_valid !== 1'b1 || resp_data !== 32'h1234_5678) begin tests_failed++; $display("FAIL lw_resp act=%0b/%h exp=1/12345678", resp_valid, resp_data); end
        next_cycle();
        tests_run++; if (resp_valid !== 1'b0 || resp_data !== 32'h1234_5678) begin tests_failed++; $display("FAIL lw_hold act=%0b/%h exp=0/12345678", resp_valid, resp_data); end
    endtask

    task automatic test_bad_size;
        write_done = 1'b1;
        drive_req(1'b1, 2'd3, 1'b0, 32'h400, 32'h5555_5555);
        tests_run++; if (resp_valid !== 1'b1 || resp_error !== 1'b1) begin tests_failed++; $display("FAIL bs_err act=%0b/%0b exp=1/1", resp_valid, resp_error); end
        tests_run++; if (write_data_valid !== 1'b0 || resp_data !== 32'h0) begin tests_failed++; $display("FAIL bs_nowrite act=%0b/%h exp=0/0", write_data_valid, resp_data); end
        next_cycle();
        tests_run++; if (resp_valid !== 1'b0 || resp_error !== 1'b1 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL bs_hold act=%0b/%0b/%0b exp=0/1/1", resp_valid, resp_error, req_ready); end
        write_done = 1'b0;
    endtask

    task automatic test_misalign;
        write_done = 1'b1;
        drive_req(1'b1, 2'd2, 1'b0, 32'h102, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
        tests_run++; if (resp_valid !== 1'b1 || resp_error !== 1'b1 || write_data_valid !== 1'b0) begin tests_failed++; $display("FAIL ma_trap act=%0b/%0b/%0b exp=1/1/0", resp_valid, resp_error, write_data_valid); end
        next_cycle();
`else
        tests_run++; if (write_data_valid !== 1'b1 || write_addr !== 32'h102) begin tests_failed++; $display("FAIL ma_issue act=%0b/%h exp=1/102", write_data_valid, write_addr); end
        next_cycle();
        tests_run++; if (resp_valid !== 1'b1 || resp_error !== 1'b0) begin tests_failed++; $display("FAIL ma_resp act=%0b/%0b exp=1/0", resp_valid, resp_error); end
        next_cycle();
`endif
        write_done = 1'b0;
    endtask

    task automatic test_reset_mid_store;
        write_done = 1'b0;
        drive_req(1'b1, 2'd2, 1'b0, 32'h500, 32'h0BAD_CAFE);
        tests_run++; if (write_data_valid !== 1'b1) begin tests_failed++; $display("FAIL rm_pre act=%0b exp=1", write_data_valid); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (write_data_valid !== 1'b0 || req_ready !== 1'b1 || bytes_to_write !== 3'd0) begin tests_failed++; $display("FAIL rm_async act=%0b/%0b/%0d exp=0/1/0", write_data_valid, req_ready, bytes_to_write); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || write_addr !== 32'h0) begin tests_failed++; $display("FAIL rm_after act=%0b/%0b/%h exp=0/1/0", resp_valid, req_ready, write_addr); end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        int first = -1;
        int last = -1;
        int bad_gap = 0;
        fetch_done = 1'b1;
        fetched_data = 32'h0000_0011;
        req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h600; req_wdata = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 11) req_valid = 1'b0;
            if (resp_valid === 1'b1) begin
                if (last >= 0 && (i - last) != 3) bad_gap++;
                if (first < 0) first = i;
                last = i;
                pulses++;
            end
        end
        req_valid = 1'b0;
        fetch_done = 1'b0;
        tests_run++; if (pulses !== 4) begin tests_failed++; $display("FAIL b2b_pulses act=%0d exp=4", pulses); end
        tests_run++; if (first !== 1 || bad_gap !== 0) begin tests_failed++; $display("FAIL b2b_spacing first=%0d badgaps=%0d exp=1/0", first, bad_gap); end
        next_cycle();
        tests_run++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_end act=%0b/%0b exp=1/0", req_ready, resp_valid); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        fetched_data = 32'h0; fetch_done = 1'b0; write_done = 1'b0;
        test_reset();
        test_store_word();
        test_store_stall();
        test_load();
        test_bad_size();
        test_misalign();
        test_reset_mid_store();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
